// File: rtl/hilo_mult_ctrl.sv
// HI/LO multiply controller: hands operand magnitudes to the iterative multiplier,
// stalls the pipeline for the transaction and commits the sign-corrected product.
//
// state | meaning
// IDLE  | waiting for an issued MULT/MULTU; HI/LO readable
// REQ   | one-cycle in_valid pulse to the multiplier
// WAIT  | waiting for out_valid, bounded by TIMEOUT
// FIX   | sign correction and HI/LO commit
module hilo_mult_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_signed,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        pipe_stall,
    output logic        err,
    output logic        mul_in_valid,
    output logic [31:0] mul_mcand,
    output logic [31:0] mul_mplier,
    input  logic [63:0] mul_product,
    input  logic        mul_out_valid
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIX} state_t;

    state_t      state_r, state_nx;
    logic [7:0]  cnt_r;
    logic        neg_r;
    logic        err_r;
    logic [63:0] prod_r;
    logic [31:0] hi_r, lo_r;
    logic        timeout_hit;

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
        return (sgn & x[31]) ? (~x + 32'd1) : x;
    endfunction

    assign timeout_hit = (cnt_r == 8'(TIMEOUT - 1));

    always_comb begin
        state_nx     = state_r;
        mul_in_valid = 1'b0;
        pipe_stall   = (state_r != IDLE);
        case (state_r)
            IDLE: if (issue_valid) state_nx = REQ;
            REQ: begin
                mul_in_valid = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (mul_out_valid)    state_nx = FIX;
                else if (timeout_hit) state_nx = IDLE;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            neg_r      <= 1'b0;
            err_r      <= 1'b0;
            prod_r     <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else begin
            state_r <= state_nx;
            case (state_r)
                IDLE: begin
                    if (issue_valid) begin
                        mul_mcand  <= mag(issue_signed, rs_data);
                        mul_mplier <= mag(issue_signed, rt_data);
                        neg_r      <= issue_signed & (rs_data[31] ^ rt_data[31]);
                        err_r      <= 1'b0;
                        cnt_r      <= '0;
                    end
                end
                WAIT: begin
                    // a product arriving on the last allowed cycle still wins over the abort
                    if (mul_out_valid)    prod_r <= mul_product;
                    else if (timeout_hit) err_r  <= 1'b1;
                    else                  cnt_r  <= cnt_r + 8'd1;
                end
                FIX: {hi_r, lo_r} <= neg_r ? (~prod_r + 64'd1) : prod_r;
                default: ;
            endcase
        end
    end

    assign err     = err_r;
    assign mf_data = mf_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Bench for hilo_mult_ctrl: timeline model of stall/commit behaviour plus directed
// literal cases, followed by randomized issues with a variable-latency responder.
module tb_hilo_mult_ctrl;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_signed = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        mf_sel = 1'b0;
    logic [31:0] mf_data;
    logic        pipe_stall, err, mul_in_valid;
    logic [31:0] mul_mcand, mul_mplier;
    logic [63:0] mul_product;
    logic        mul_out_valid;
    logic        stray = 1'b0;
    int          next_k = 2;

    int n_chk = 0;
    int n_fail = 0;

    hilo_mult_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_signed(issue_signed),
        .rs_data(rs_data), .rt_data(rt_data), .mf_sel(mf_sel), .mf_data(mf_data),
        .pipe_stall(pipe_stall), .err(err), .mul_in_valid(mul_in_valid),
        .mul_mcand(mul_mcand), .mul_mplier(mul_mplier), .mul_product(mul_product),
        .mul_out_valid(mul_out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] ref_mag(input logic s, input logic [31:0] x);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Timeline model: an accepted issue stalls for 2+k cycles (product returned)
    // or 1+T cycles (abort); the outcome lands on the edge ending the stall.
    int          stall_left;
    logic        pend_ok, exp_iv, exp_err;
    logic [63:0] pend;
    logic [31:0] exp_hi, exp_lo, exp_mcand, exp_mplier;
    int          mdl_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_left <= 0; pend_ok <= 1'b0; pend <= '0; exp_iv <= 1'b0; exp_err <= 1'b0;
            exp_hi <= '0; exp_lo <= '0; exp_mcand <= '0; exp_mplier <= '0; mdl_k <= 0;
        end else begin
            exp_iv <= 1'b0;
            if (stall_left > 0) begin
                stall_left <= stall_left - 1;
                if (stall_left == 1) begin
                    if (pend_ok) {exp_hi, exp_lo} <= pend;
                    else         exp_err <= 1'b1;
                end
            end else if (issue_valid) begin
                pend       <= ref_prod(issue_signed, rs_data, rt_data);
                pend_ok    <= (next_k >= 1 && next_k <= T);
                stall_left <= (next_k >= 1 && next_k <= T) ? 2 + next_k : 1 + T;
                exp_err    <= 1'b0;
                exp_iv     <= 1'b1;
                exp_mcand  <= ref_mag(issue_signed, rs_data);
                exp_mplier <= ref_mag(issue_signed, rt_data);
                mdl_k      <= next_k;
            end
        end
    end

    // Multiplier stand-in: out_valid k cycles after in_valid (k=0 never answers).
    int          rcnt;
    logic [63:0] junk;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= 0;
            junk <= '0;
        end else begin
            junk <= {$urandom, $urandom};
            if (mul_in_valid)  rcnt <= mdl_k;
            else if (rcnt > 0) rcnt <= rcnt - 1;
        end
    end
    assign mul_out_valid = (rcnt == 1) || stray;
    assign mul_product   = (rcnt == 1) ? {32'b0, mul_mcand} * {32'b0, mul_mplier} : junk;

    int st_cnt, iv_cnt;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cnt <= 0;
            iv_cnt <= 0;
        end else begin
            if (pipe_stall)   st_cnt <= st_cnt + 1;
            if (mul_in_valid) iv_cnt <= iv_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        chk("stall", 64'(pipe_stall), 64'(stall_left != 0));
        chk("in_valid", 64'(mul_in_valid), 64'(exp_iv));
        chk("err", 64'(err), 64'(exp_err));
        chk("mf_data", 64'(mf_data), 64'(mf_sel ? exp_hi : exp_lo));
        chk("mcand", 64'(mul_mcand), 64'(exp_mcand));
        chk("mplier", 64'(mul_mplier), 64'(exp_mplier));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && pipe_stall; i++) @(negedge clk);
        if (pipe_stall) chk("idle_timeout", 64'(pipe_stall), 64'd0);
        #1;
    endtask

    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int k, input int hold, output int stalls, output int ivs);
        int st0, iv0;
        @(negedge clk); #1;
        st0 = st_cnt; iv0 = iv_cnt;
        issue_valid = 1'b1; issue_signed = s; rs_data = a; rt_data = b; next_k = k;
        repeat (hold) @(negedge clk);
        #1;
        issue_valid = 1'b0;
        wait_idle();
        stalls = st_cnt - st0;
        ivs    = iv_cnt - iv0;
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
        chk({name, "_model_hi"}, 64'(exp_hi), 64'(hi));
        chk({name, "_model_lo"}, 64'(exp_lo), 64'(lo));
        mf_sel = 1'b1; #1;
        chk({name, "_mfhi"}, 64'(mf_data), 64'(hi));
        mf_sel = 1'b0; #1;
        chk({name, "_mflo"}, 64'(mf_data), 64'(lo));
    endtask

    logic chk_en = 1'b0;
    int   stalls, ivs;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst_n && chk_en) compare_cycle();
            end
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 64'(pipe_stall), 64'd0);
        chk("rst_mf", 64'(mf_data), 64'd0);
        chk("rst_mcand", 64'({mul_mcand, mul_mplier}), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1, stalls, ivs);
        chk("multu_max_stalls", 64'(stalls), 64'd4);
        chk("multu_max_pulses", 64'(ivs), 64'd1);
        chk_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        do_op(1'b1, 32'hFFFF_FFFD, 32'd7, 2, 1, stalls, ivs);
        chk("m3x7_mcand", 64'(mul_mcand), 64'd3);
        chk("m3x7_mplier", 64'(mul_mplier), 64'd7);
        chk_hilo("m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1, 1, stalls, ivs);
        chk("min_mags", 64'({mul_mcand, mul_mplier}), 64'h8000_0000_8000_0000);
        chk("min_stalls_k1", 64'(stalls), 64'd3);
        chk_hilo("min_sq", 32'h4000_0000, 32'h0);

        do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 3, 1, stalls, ivs);
        chk_hilo("m5x0", 32'h0, 32'h0);

        do_op(1'b0, 32'd5, 32'd6, T, 1, stalls, ivs);
        chk("k_eq_T_stalls", 64'(stalls), 64'(2 + T));
        chk_hilo("u5x6", 32'h0, 32'd30);

        do_op(1'b1, 32'd9, 32'd9, 0, 1, stalls, ivs);
        chk("timeout_stalls", 64'(stalls), 64'(1 + T));
        chk("timeout_err", 64'(err), 64'd1);
        chk_hilo("timeout_keep", 32'h0, 32'd30);

        do_op(1'b0, 32'd3, 32'd4, 5, 4, stalls, ivs);
        chk("err_cleared", 64'(err), 64'd0);
        chk("held_issue_pulses", 64'(ivs), 64'd1);
        chk_hilo("u3x4", 32'h0, 32'd12);

        @(negedge clk); #1;
        issue_valid = 1'b1; issue_signed = 1'b1; rs_data = 32'hDEAD_BEEF; rt_data = 32'd77; next_k = 0;
        @(negedge clk); #1;
        issue_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0; #1;
        chk("midrst_stall", 64'(pipe_stall), 64'd0);
        chk("midrst_iv_err", 64'({mul_in_valid, err}), 64'd0);
        chk("midrst_ops", 64'({mul_mcand, mul_mplier}), 64'd0);
        mf_sel = 1'b1; #1;
        chk("midrst_mfhi", 64'(mf_data), 64'd0);
        mf_sel = 1'b0; #1;
        chk("midrst_mflo", 64'(mf_data), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1; stray = 1'b1;
        @(negedge clk); #1;
        stray = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("stray_stall", 64'(pipe_stall), 64'd0);
        chk_hilo("stray", 32'h0, 32'h0);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            issue_valid  = ($urandom_range(0, 2) == 0);
            issue_signed = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       rs_data = 32'h8000_0000;
                1:       rs_data = 32'h0;
                2:       rs_data = 32'hFFFF_FFFF;
                default: rs_data = $urandom;
            endcase
            rt_data = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            next_k  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, T + 2) : $urandom_range(1, 3);
            mf_sel  = $urandom_range(0, 1);
            stray   = (stall_left == 0) && ($urandom_range(0, 4) == 0);
        end
        @(negedge clk); #1;
        issue_valid = 1'b0;
        stray = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_mult_ctrl.md
# hilo_mult_ctrl

Processor-side controller for the iterative multiplier. It accepts MULT/MULTU from the decode stage and converts signed operands to magnitudes. It drives the multiplier's in_valid/operand handshake, waits for out_valid, applies sign correction and commits the 64-bit result to the HI/LO registers. It stalls the pipeline for the whole transaction and serves MFHI/MFLO reads from HI/LO.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before the transaction is aborted (range 2..255).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode stage presents a multiply this cycle.
- issue_signed  in  1  1 = MULT (two's complement), 0 = MULTU.
- rs_data  in  32  multiplicand operand.
- rt_data  in  32  multiplier operand.
- mf_sel  in  1  0 = read LO, 1 = read HI.
- mf_data  out  32  combinational: mf_sel ? hi_r : lo_r.
- pipe_stall  out  1  pipeline hold request.
- err  out  1  sticky timeout flag.
- mul_in_valid  out  1  one-cycle request pulse to the multiplier.
- mul_mcand  out  32  registered operand magnitude A.
- mul_mplier  out  32  registered operand magnitude B.
- mul_product  in  64  unsigned product from the multiplier.
- mul_out_valid  in  1  product valid.

Reset is asynchronous and active-low; clock and reset are named clk and rst_n.

## Operation
- State machine: IDLE, REQ, WAIT, FIX.
- IDLE:
  - issue_valid=1: latch mag(rs_data) into mul_mcand and mag(rt_data) into mul_mplier. Latch neg = issue_signed & (rs_data[31] ^ rt_data[31]). Clear err and the timeout counter. Go to REQ.
  - Otherwise stay in IDLE.
- mag(x) is (issue_signed & x[31]) ? (~x + 1) : x, 32-bit unsigned. mag(0x80000000) = 0x80000000 exactly.
- REQ: mul_in_valid=1 for exactly this cycle. Go to WAIT unconditionally.
- WAIT:
  - mul_out_valid=1: capture mul_product into prod_r and go to FIX.
  - Otherwise increment the counter.
  - When counter == TIMEOUT-1 with no out_valid: set err=1, leave HI/LO unchanged, go to IDLE.
- FIX: {hi_r, lo_r} <= neg ? (~prod_r + 1) : prod_r (64-bit wrap). Go to IDLE.
- pipe_stall = (state != IDLE). It is combinational from the state register.
- issue_valid outside IDLE is ignored; no queuing.
- mul_out_valid outside WAIT is ignored.
- mf_data is valid only while pipe_stall=0. During a transaction it shows the old HI/LO.
- Reset values:
  - state=IDLE.
  - hi_r=lo_r=0.
  - mul_mcand=mul_mplier=0.
  - mul_in_valid=0, pipe_stall=0, err=0, mf_data=0.
- Reset asserted mid-transaction: immediate return to IDLE with all of the above values. Any result in flight is discarded.

## Timing
- Edge t0: issue accepted.
- Cycle t0+1: REQ, mul_in_valid=1, pipe_stall=1.
- WAIT starts at t0+2.
- With a multiplier that raises out_valid k cycles after in_valid (k≥1), the product is captured at the end of cycle t0+1+k. FIX follows in cycle t0+2+k.
- HI/LO are updated and pipe_stall=0 at cycle t0+3+k.
- For the current 3-state multiplier (k=2), pipe_stall is high for 4 cycles and HI/LO are readable 5 cycles after issue.
- A back-to-back issue is accepted in the first IDLE cycle.
- Timeout: pipe_stall is high 1+TIMEOUT cycles, then err=1 from the next cycle until the next accepted issue.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - Exactly one mul_in_valid pulse.
  - pipe_stall high 4 cycles with the k=2 responder.
- MULT 0xFFFFFFFD (−3) × 7:
  - mul_mcand=3, mul_mplier=7.
  - Result HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000:
  - Both magnitudes 0x80000000.
  - HI=0x40000000, LO=0.
- MULT −5 × 0 → HI=LO=0 (negation of zero stays zero). MFHI/MFLO via mf_sel then return 0.
- Responder that never asserts out_valid, TIMEOUT=8:
  - err rises after 9 stalled cycles.
  - HI/LO keep the previous values.
  - The next issue clears err.
- Reset mid-WAIT, then a stray mul_out_valid:
  - Outputs are zero at once.
  - State stays IDLE; HI/LO stay 0.
- issue_valid pulsed during WAIT: ignored, no second mul_in_valid.
